serial_word_tx: RTL and testbench
=================================

Name: serial_word_tx

Overview:
- Upstream feeder for the seq_1001 sequence detector: accepts parallel words over a valid/ready handshake and serializes them onto a single-bit stream (ser_out → seq_1001.din), one bit per clk.
- One-entry holding register behind the shifter gives gap-free back-to-back streaming.
- Drives IDLE_BIT when no word is in flight.
- Keeps a wrapping count of completed words for debug/scoreboarding.

Parameters:
- WIDTH, 8, bits per word (legal range 2..32).
- MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first.
- IDLE_BIT, 0, value driven on ser_out while idle.
- CNT_W, 16, width of words_sent counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  WIDTH  word to serialize.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a word this cycle.
- ser_out  out  1  serial bit (to seq_1001.din).
- ser_valid  out  1  ser_out carries a data bit (not idle fill).
- word_done  out  1  high during the cycle the last bit of a word is on ser_out.
- busy  out  1  shifter or holding register occupied.
- words_sent  out  CNT_W  completed-word count, wraps to 0.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; shifter and holding register empty.
  - ser_out=IDLE_BIT; ser_valid=0; word_done=0; busy=0; words_sent=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-word discards the word in flight and any held word; no partial-word completion is counted.
- Accept: the handshake fires at an edge where in_valid & in_ready=1. in_ready = !hold_valid (combinational from registers only, not from in_valid).
- FSM states:
  - IDLE: shifter empty.
  - SHIFT: shifter presenting bits; bit_cnt counts 0..WIDTH-1.
- Transitions:
  - IDLE + accept → SHIFT. The word loads directly into the shifter. Its first bit is on ser_out in the cycle after the accept edge (latency 1), with ser_valid=1.
  - SHIFT, bit_cnt < WIDTH-1 → advance one bit per edge.
    - An accept in this state writes the holding register (hold_valid=1).
  - SHIFT, bit_cnt = WIDTH-1 (word_done=1, this edge increments words_sent):
    - hold_valid=1 → holding word moves into the shifter and hold_valid clears. The next word's first bit follows with no gap; stay in SHIFT.
    - hold_valid=0 and accept this edge → the new word loads directly into the shifter, no gap; stay in SHIFT.
    - Otherwise → IDLE; ser_out=IDLE_BIT; ser_valid=0.
- Bit order:
  - MSB_FIRST=1: bit WIDTH-1 first.
  - MSB_FIRST=0: bit 0 first.
- All outputs except in_ready are registered.
- busy = (state==SHIFT) | hold_valid.
- words_sent wraps from 2^CNT_W-1 to 0.
- Boundaries:
  - Hold full → in_ready=0. in_valid is ignored with no side effect; the upstream must hold in_data stable.
  - No framing is added. Detector matches that span word boundaries or idle fill are legitimate and expected.

Decomposition:
- Shared package seq_pkg holds:
  - state enum {IDLE, SHIFT}.
  - default WIDTH constant.
  - IDLE_BIT default.
  - the 1001 pattern constant, shared with the detector and the bench.
- One natural sub-module: piso_shift_reg. It provides parallel load, a 1-bit shift selectable by MSB_FIRST, and a current-bit output.
- The FSM, holding register and counter stay in the top.

Test Plan:
- Reset, then idle 5 cycles → ser_out=0, ser_valid=0, in_ready=1, busy=0, words_sent=0.
- WIDTH=4, MSB_FIRST=1, accept 4'b1001 at edge T → ser_out=1,0,0,1 in cycles T+1..T+4 with ser_valid=1. word_done only in T+4. ser_out=0, ser_valid=0 from T+5. words_sent=1.
- WIDTH=4, back-to-back 4'hA then 4'h5, in_valid held high → second accept goes to hold and in_ready=0 until hold drains. ser_out=1,0,1,0,0,1,0,1 contiguous, ser_valid never drops. words_sent=2.
- MSB_FIRST=0, accept 4'b0001 → ser_out=1,0,0,0.
- rst asserted after 2 bits of 4'hF with a held word 4'h3 → next cycle idle. Hold cleared, in_ready=1, words_sent unchanged (0).
- CNT_W=2, stream 5 words → words_sent sequence 1,2,3,0,1. With ser_out chained to seq_1001, dout asserts for streamed 4'b1001 words and never asserts for an all-zero stream.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial word transmitter and the 1001 sequence detector.
package seq_pkg;

    // Transmitter control states.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

    // Default word width.
    localparam int DEFAULT_WIDTH = 8;

    // Default line level while no word is in flight.
    localparam logic DEFAULT_IDLE_BIT = 1'b0;

    // Pattern matched by the downstream detector.
    localparam logic [3:0] PATTERN_1001 = 4'b1001;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shifter. Vacated positions fill with FILL_BIT, so that
// once a word has fully drained the current-bit output rests at the fill level.
module piso_shift_reg
    import seq_pkg::*;
#(
    parameter int   WIDTH     = DEFAULT_WIDTH,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic FILL_BIT  = DEFAULT_IDLE_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             bit_out
);

    logic [WIDTH-1:0] sr;

    // Shift register: load takes priority over shift; reset fills with FILL_BIT.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            sr <= {WIDTH{FILL_BIT}};
        end else if (load) begin
            sr <= load_data;
        end else if (shift) begin
            sr <= MSB_FIRST ? {sr[WIDTH-2:0], FILL_BIT} : {FILL_BIT, sr[WIDTH-1:1]};
        end
    end

    assign bit_out = MSB_FIRST ? sr[WIDTH-1] : sr[0];

endmodule

// File: rtl/serial_word_tx.sv
// Serializes valid/ready words onto a single-bit stream, one bit per clk, with a
// one-word holding register for gap-free back-to-back streaming.
module serial_word_tx
    import seq_pkg::*;
#(
    parameter int   WIDTH     = DEFAULT_WIDTH,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT,
    parameter int   CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

    localparam int              BC_W     = $clog2(WIDTH);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

    tx_state_t        state, state_d;
    logic [BC_W-1:0]  bit_cnt, bit_cnt_d;
    logic             hold_valid, hold_valid_d;
    logic [WIDTH-1:0] hold_data;
    logic             hold_wr;
    logic             sr_load, sr_shift;
    logic [WIDTH-1:0] sr_data;
    logic             accept;
    logic             last_bit;

    // in_ready depends only on registered state, never on in_valid.
    assign in_ready = !hold_valid;
    assign accept   = in_valid && !hold_valid;
    assign last_bit = (state == SHIFT) && (bit_cnt == LAST_BIT);

    // Next-state logic: decides shifter load/shift and holding-register writes.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d      = state;
        bit_cnt_d    = bit_cnt;
        hold_valid_d = hold_valid;
        hold_wr      = 1'b0;
        sr_load      = 1'b0;
        sr_shift     = 1'b0;
        sr_data      = in_data;
        case (state)
            IDLE: begin
                if (accept) begin
                    sr_load   = 1'b1;
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    sr_shift  = 1'b1;
                    bit_cnt_d = bit_cnt + BC_W'(1);
                    if (accept) begin
                        hold_wr      = 1'b1;
                        hold_valid_d = 1'b1;
                    end
                end else if (hold_valid) begin
                    sr_load      = 1'b1;
                    sr_data      = hold_data;
                    hold_valid_d = 1'b0;
                    bit_cnt_d    = '0;
                end else if (accept) begin
                    sr_load   = 1'b1;
                    bit_cnt_d = '0;
                end else begin
                    // One more shift leaves only fill bits, so ser_out drops to IDLE_BIT.
                    sr_shift  = 1'b1;
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            hold_valid <= 1'b0;
        end else begin
            state      <= state_d;
            bit_cnt    <= bit_cnt_d;
            hold_valid <= hold_valid_d;
        end
    end

    // Holding-register payload.
    always_ff @(posedge clk) begin
        // NOTE: pure datapath, no reset needed; hold_valid alone qualifies it.
        if (hold_wr) begin
            hold_data <= in_data;
        end
    end

    // Registered status outputs, derived from next-state values, plus the word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ser_valid  <= 1'b0;
            word_done  <= 1'b0;
            busy       <= 1'b0;
            words_sent <= '0;
        end else begin
            ser_valid <= (state_d == SHIFT);
            word_done <= (state_d == SHIFT) && (bit_cnt_d == LAST_BIT);
            busy      <= (state_d == SHIFT) || hold_valid_d;
            if (last_bit) begin
                words_sent <= words_sent + CNT_W'(1);
            end
        end
    end

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .FILL_BIT  (IDLE_BIT)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (sr_load),
        .shift     (sr_shift),
        .load_data (sr_data),
        .bit_out   (ser_out)
    );

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed self-checking bench: an MSB-first 4-bit instance with a 2-bit counter
// and an LSB-first 4-bit instance, plus a small 1001 detector model on the MSB stream.
module tb_serial_word_tx;
    import seq_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [W-1:0] m_data;
    logic         m_valid, m_ready, m_ser, m_sv, m_done, m_busy;
    logic [1:0]   m_cnt;

    logic [W-1:0] l_data;
    logic         l_valid, l_ready, l_ser, l_sv, l_done, l_busy;
    logic [15:0]  l_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    serial_word_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(2)) u_msb (
        .clk(clk), .rst(rst), .in_data(m_data), .in_valid(m_valid), .in_ready(m_ready),
        .ser_out(m_ser), .ser_valid(m_sv), .word_done(m_done), .busy(m_busy),
        .words_sent(m_cnt)
    );

    serial_word_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .CNT_W(16)) u_lsb (
        .clk(clk), .rst(rst), .in_data(l_data), .in_valid(l_valid), .in_ready(l_ready),
        .ser_out(l_ser), .ser_valid(l_sv), .word_done(l_done), .busy(l_busy),
        .words_sent(l_cnt)
    );

    // Reference 1001 detector on the MSB stream: last three bits plus the current one.
    logic [2:0] hist;
    logic       det;
    assign det = ({hist, m_ser} == PATTERN_1001);
    always @(posedge clk) begin
        if (rst) hist <= '0;
        else     hist <= {hist[1:0], m_ser};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        m_valid = 1'b0;
        l_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [3:0] exp4;
    logic [7:0] exp8;
    int         budget;
    int         hits;

    initial begin
        rst = 1'b1; m_valid = 1'b0; l_valid = 1'b0; m_data = '0; l_data = '0;
        do_reset();

        // Reset and idle.
        repeat (5) tick();
        check("idle_ser", m_ser, 0);
        check("idle_sv", m_sv, 0);
        check("idle_ready", m_ready, 1);
        check("idle_busy", m_busy, 0);
        check("idle_cnt", m_cnt, 0);
        check("idle_done", m_done, 0);
        check("idle_lsb_ser", l_ser, 0);

        // Single word 1001, MSB first.
        exp4 = 4'b1001;
        m_data = exp4; m_valid = 1'b1;
        tick();
        m_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("single_bit%0d", i), m_ser, exp4[3-i]);
            check($sformatf("single_sv%0d", i), m_sv, 1);
            check($sformatf("single_done%0d", i), m_done, (i == 3) ? 1 : 0);
            tick();
        end
        check("single_after_ser", m_ser, 0);
        check("single_after_sv", m_sv, 0);
        check("single_cnt", m_cnt, 1);
        check("single_busy", m_busy, 0);

        // Back-to-back A then 5 through the holding register.
        do_reset();
        exp8 = 8'hA5;
        m_data = 4'hA; m_valid = 1'b1;
        tick();
        m_data = 4'h5;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("b2b_bit%0d", i), m_ser, exp8[7-i]);
            check($sformatf("b2b_sv%0d", i), m_sv, 1);
            check($sformatf("b2b_ready%0d", i), m_ready, (i == 0 || i >= 4) ? 1 : 0);
            tick();
            if (i == 0) m_valid = 1'b0;
        end
        check("b2b_after_sv", m_sv, 0);
        check("b2b_cnt", m_cnt, 2);

        // LSB first, word 0001.
        exp4 = 4'b0001;
        l_data = exp4; l_valid = 1'b1;
        tick();
        l_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lsb_bit%0d", i), l_ser, exp4[i]);
            check($sformatf("lsb_sv%0d", i), l_sv, 1);
            tick();
        end
        check("lsb_after_sv", l_sv, 0);
        check("lsb_cnt", l_cnt, 1);

        // Reset mid-word with a held word.
        do_reset();
        m_data = 4'hF; m_valid = 1'b1;
        tick();
        m_data = 4'h3;
        tick();
        m_valid = 1'b0;
        check("mid_ser", m_ser, 1);
        check("mid_busy", m_busy, 1);
        check("mid_ready", m_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_ser", m_ser, 0);
        check("rst_sv", m_sv, 0);
        check("rst_ready", m_ready, 1);
        check("rst_busy", m_busy, 0);
        check("rst_cnt", m_cnt, 0);
        repeat (6) tick();
        check("rst_later_sv", m_sv, 0);
        check("rst_later_cnt", m_cnt, 0);

        // Counter wrap with CNT_W=2, stream of 1001 words into the detector.
        do_reset();
        m_data = 4'b1001; m_valid = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            budget = 20;
            while (!m_done && budget > 0) begin
                tick();
                budget--;
            end
            check($sformatf("cnt_done_seen%0d", n), m_done, 1);
            check($sformatf("cnt_det%0d", n), det, 1);
            tick();
            check($sformatf("cnt_words%0d", n), m_cnt, n % 4);
        end
        m_valid = 1'b0;
        repeat (12) tick();

        // All-zero stream never triggers the detector.
        do_reset();
        m_data = 4'h0; m_valid = 1'b1;
        hits = 0;
        repeat (16) begin
            tick();
            if (det) hits++;
        end
        check("zero_sv", m_sv, 1);
        m_valid = 1'b0;
        repeat (8) tick();
        check("zero_det_hits", hits, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
